// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM state type and counter-width helper for the load/store unit.
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} lsu_state_t;

    function automatic int lat_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load extract/extend and store byte-lane merge (combinational).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [1:0]  offs_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [4:0]  sh;
    logic [31:0] sw;
    logic [31:0] mask;

    // Size 11 falls through to the word path; half ignores offs_i[0].
    always_comb begin
        sh      = size_i == SZ_BYTE ? {offs_i, 3'b000} : size_i == SZ_HALF ? {offs_i[1], 4'b0000} : 5'd0;
        sw      = word_i >> sh;
        mask    = (size_i == SZ_BYTE ? 32'h0000_00FF : size_i == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
        load_o  = size_i == SZ_BYTE ? {{24{sign_i & sw[7]}}, sw[7:0]} :
                  size_i == SZ_HALF ? {{16{sign_i & sw[15]}}, sw[15:0]} : sw;
        store_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator for the word-addressed data memory.
// Define MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of forcing alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LATENCY = 1,
    parameter int MEM_IDX_W      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_MemR,
    output logic        mem_MemW,
    input  logic [31:0] mem_readData
);
    localparam int CW = lat_cnt_w(MEM_RD_LATENCY);

    lsu_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_store_q, signed_q, err_q;
    logic [1:0]           size_q, offs_q;
    logic [MEM_IDX_W-1:0] addr_q;
    logic [31:0]          wdata_q, rdata_q, ld_word, st_word;
    logic                 accept, rd_done, mis;
    logic                 unused_addr;

    assign unused_addr = ^req_addr[31:MEM_IDX_W+2];

`ifdef MISALIGN_TRAP_EN
    assign mis = (req_size == SZ_HALF && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign accept        = state_q == IDLE && req_valid;
    assign rd_done       = state_q == RD_WAIT && cnt_q == CW'(MEM_RD_LATENCY);
    assign req_ready     = state_q == IDLE;
    assign mem_MemR      = state_q == RD;
    assign mem_MemW      = state_q == WR;
    assign resp_valid    = state_q == RESP;
    assign resp_err      = resp_valid & err_q;
    assign resp_rdata    = rdata_q;
    assign mem_address   = 32'(addr_q);
    assign mem_writeData = wdata_q;

    lsu_align u_align (
        .size_i (size_q),
        .sign_i (signed_q),
        .offs_i (offs_q),
        .word_i (mem_readData),
        .wdata_i(wdata_q),
        .load_o (ld_word),
        .store_o(st_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = mis ? RESP : (req_is_store && req_size[1]) ? WR : RD;
            RD: begin
                state_d = RD_WAIT;
                cnt_d   = CW'(1);
            end
            RD_WAIT: if (rd_done) state_d = is_store_q ? WR : RESP;
                     else cnt_d = cnt_q + CW'(1);
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            signed_q   <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= '0;
            offs_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                is_store_q <= req_is_store;
                signed_q   <= req_signed;
                err_q      <= mis;
                size_q     <= req_size;
                offs_q     <= req_addr[1:0];
                addr_q     <= req_addr[MEM_IDX_W+1:2];
                wdata_q    <= req_wdata;
                rdata_q    <= '0;
            end
            // Sub-word stores reuse the write-data register to hold the merged word.
            if (rd_done) begin
                if (is_store_q) wdata_q <= st_word;
                else rdata_q <= ld_word;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed checks of two LSUs (latency 1 and 3) against a byte-level model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        preload = 1'b0;
    logic        req_valid = 1'b0, req_is_store = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready [2], resp_valid [2], resp_err [2], mem_MemR [2], mem_MemW [2];
    logic [31:0] resp_rdata [2], mem_address [2], mem_writeData [2], mem_readData [2];
    logic [31:0] ref_mem [16];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LT = (g == 0) ? 1 : 3;
        logic [31:0] mem [1024];
        logic [31:0] pipe [LT];
        load_store_unit #(.MEM_RD_LATENCY(LT), .MEM_IDX_W(10)) dut (
            .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[g]),
            .req_is_store(req_is_store), .req_size(req_size), .req_signed(req_signed),
            .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .mem_address(mem_address[g]),
            .mem_writeData(mem_writeData[g]), .mem_MemR(mem_MemR[g]), .mem_MemW(mem_MemW[g]),
            .mem_readData(mem_readData[g])
        );
        always @(posedge clk) begin
            if (preload) for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
            else if (mem_MemW[g]) mem[mem_address[g][9:0]] <= mem_writeData[g];
            pipe[0] <= mem_MemR[g] ? mem[mem_address[g][9:0]] : 32'hDEAD_BEEF;
            for (int i = 1; i < LT; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_readData[g] = pipe[LT-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input int idx);
        chk("mem_L1", u[0].mem[idx], ref_mem[idx]);
        chk("mem_L3", u[1].mem[idx], ref_mem[idx]);
    endtask

    task automatic run(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] r0);
        int idx, nb, sb, lt;
        logic trap;
        logic [31:0] old, ld, nw_word;
        int nr [2], nw [2], nv [2], rc [2], wc [2], vc [2], both [2], abad [2];
        int erd, ewr, ersp;
        logic [31:0] wdat [2], rdat [2];
        logic err [2], rdy1 [2], rdya [2];
        idx = int'(a[11:2]);
        nb = sz == SZ_BYTE ? 1 : sz == SZ_HALF ? 2 : 4;
        sb = sz == SZ_BYTE ? int'(a[1:0]) : sz == SZ_HALF ? (a[1] ? 2 : 0) : 0;
`ifdef MISALIGN_TRAP_EN
        trap = (sz == SZ_HALF && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`else
        trap = 1'b0;
`endif
        old = ref_mem[idx];
        ld = '0;
        nw_word = old;
        for (int b = 0; b < nb; b++) begin
            ld[8*b +: 8] = old[8*(sb+b) +: 8];
            nw_word[8*(sb+b) +: 8] = wd[8*b +: 8];
        end
        if (sg && nb < 4 && ld[8*nb-1]) for (int b = nb; b < 4; b++) ld[8*b +: 8] = 8'hFF;
        if (st || trap) ld = '0;
        for (int g = 0; g < 2; g++) begin
            nr[g] = 0; nw[g] = 0; nv[g] = 0; rc[g] = 0; wc[g] = 0; vc[g] = 0; both[g] = 0; abad[g] = 0;
            wdat[g] = '0; rdat[g] = '0; err[g] = 1'b0; rdy1[g] = 1'b1; rdya[g] = 1'b0;
        end
        @(negedge clk);
        chk("ready_before_L1", 32'(req_ready[0]), 32'd1);
        chk("ready_before_L3", 32'(req_ready[1]), 32'd1);
        req_valid = 1'b1; req_is_store = st; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                lt = g == 0 ? 1 : 3;
                ersp = trap ? 1 : !st ? lt + 2 : nb == 4 ? 2 : lt + 3;
                if (mem_MemR[g]) begin nr[g]++; rc[g] = c; end
                if (mem_MemW[g]) begin nw[g]++; wc[g] = c; wdat[g] = mem_writeData[g]; end
                if (mem_MemR[g] && mem_MemW[g]) both[g]++;
                if (c < ersp && mem_address[g] != 32'(idx)) abad[g]++;
                if (resp_valid[g]) begin nv[g]++; vc[g] = c; rdat[g] = resp_rdata[g]; err[g] = resp_err[g]; end
                if (c == 1) rdy1[g] = req_ready[g];
                if (vc[g] != 0 && c == vc[g] + 1) rdya[g] = req_ready[g];
            end
        end
        for (int g = 0; g < 2; g++) begin
            lt = g == 0 ? 1 : 3;
            erd  = (trap || (st && nb == 4)) ? 0 : 1;
            ewr  = (trap || !st) ? 0 : nb == 4 ? 1 : lt + 2;
            ersp = trap ? 1 : !st ? lt + 2 : nb == 4 ? 2 : lt + 3;
            chk($sformatf("memr_count_L%0d", lt), 32'(nr[g]), 32'(erd));
            chk($sformatf("memr_cycle_L%0d", lt), 32'(rc[g]), 32'(erd));
            chk($sformatf("memw_count_L%0d", lt), 32'(nw[g]), 32'(ewr != 0));
            chk($sformatf("memw_cycle_L%0d", lt), 32'(wc[g]), 32'(ewr));
            chk($sformatf("resp_count_L%0d", lt), 32'(nv[g]), 32'd1);
            chk($sformatf("resp_cycle_L%0d", lt), 32'(vc[g]), 32'(ersp));
            chk($sformatf("rdata_L%0d", lt), rdat[g], ld);
            chk($sformatf("err_L%0d", lt), 32'(err[g]), 32'(trap));
            chk($sformatf("strobe_overlap_L%0d", lt), 32'(both[g]), 32'd0);
            chk($sformatf("addr_hold_L%0d", lt), 32'(abad[g]), 32'd0);
            chk($sformatf("busy_ready_L%0d", lt), 32'(rdy1[g]), 32'd0);
            chk($sformatf("ready_after_L%0d", lt), 32'(rdya[g]), 32'd1);
            if (ewr != 0) chk($sformatf("wdata_L%0d", lt), wdat[g], st && nb == 4 ? wd : nw_word);
        end
        if (st && !trap) ref_mem[idx] = nw_word;
        chk_mem(idx);
        r0 = rdat[0];
    endtask

    initial begin
        logic [31:0] r;
        int cnt_w;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'h8000_FF7F;
        rst_n = 1'b0;
        preload = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_ready", 32'(req_ready[g]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[g]), 32'd0);
            chk("rst_resp_err", 32'(resp_err[g]), 32'd0);
            chk("rst_memr", 32'(mem_MemR[g]), 32'd0);
            chk("rst_memw", 32'(mem_MemW[g]), 32'd0);
            chk("rst_rdata", resp_rdata[g], 32'd0);
            chk("rst_address", mem_address[g], 32'd0);
            chk("rst_writedata", mem_writeData[g], 32'd0);
        end
        preload = 1'b0;
        rst_n = 1'b1;

        run(1'b0, SZ_BYTE, 1'b1, 32'd4, 32'd0, r); chk("lb_4", r, 32'h0000_007F);
        run(1'b0, SZ_BYTE, 1'b1, 32'd5, 32'd0, r); chk("lb_5", r, 32'hFFFF_FFFF);
        run(1'b0, SZ_BYTE, 1'b0, 32'd5, 32'd0, r); chk("lbu_5", r, 32'h0000_00FF);
        run(1'b0, SZ_HALF, 1'b1, 32'd6, 32'd0, r); chk("lh_6", r, 32'hFFFF_8000);
        run(1'b1, SZ_BYTE, 1'b0, 32'd7, 32'h0000_00AB, r);
        chk("sb_7_mem", u[0].mem[1], 32'hAB00_FF7F);
        run(1'b0, SZ_WORD, 1'b0, 32'd4, 32'd0, r); chk("lw_4", r, 32'hAB00_FF7F);
        run(1'b1, SZ_WORD, 1'b0, 32'd8, 32'h1234_5678, r);
        run(1'b0, SZ_WORD, 1'b0, 32'd8, 32'd0, r); chk("lw_8", r, 32'h1234_5678);
        run(1'b0, SZ_WORD, 1'b0, 32'd6, 32'd0, r);
`ifdef MISALIGN_TRAP_EN
        chk("lw_6_trap", r, 32'd0);
`else
        chk("lw_6_forced", r, 32'hAB00_FF7F);
`endif
        run(1'b0, 2'b11, 1'b1, 32'h0000_1004, 32'd0, r); chk("size11_as_word", r, 32'hAB00_FF7F);
        run(1'b1, SZ_HALF, 1'b0, 32'd14, 32'hCAFE_BEEF, r);

        for (int n = 0; n < 60; n++)
            run(1'($urandom), 2'($urandom), 1'($urandom), $urandom & 32'hFFFF_F03F, $urandom, r);

        // Reset lands in RD_WAIT of a sub-word store on both instances.
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_size = SZ_BYTE; req_addr = 32'd12; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cnt_w = 0;
        @(negedge clk);
        if (mem_MemW[0] || mem_MemW[1]) cnt_w++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 2; g++) chk("ready_after_reset", 32'(req_ready[g]), 32'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_MemW[0] || mem_MemW[1] || mem_MemR[0] || mem_MemR[1] || resp_valid[0] || resp_valid[1]) cnt_w++;
        end
        chk("no_activity_after_reset", 32'(cnt_w), 32'd0);
        chk_mem(3);
        run(1'b0, SZ_WORD, 1'b0, 32'd12, 32'd0, r); chk("lw_12_after_reset", r, ref_mem[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
